// File: rtl/destuffing_rx.sv
// destuffing_rx: CAN receive-side bit destuffer with stuff-error detection.
// Define DESTUFF_STFCNT_EN to enable the modulo-8 stuff-bit counter on stfcnt.
module destuffing_rx #(
    parameter int STUFF_LEN = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bitin,
    input  logic       activ,
    input  logic       direct,
    output logic       bitout,
    output logic       valid,
    output logic       stuff,
    output logic       stferr,
    output logic [2:0] stfcnt
);

    localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);

    logic [2:0] count;
    logic       run_bit;
    logic       edged;
    logic       strobe;
    logic       stuff_hit;

    // One processed bit per rising edge of the strobe level.
    assign strobe    = activ && !edged;
    assign stuff_hit = strobe && !direct && (count == RUN_MAX)
                       && (bitin != run_bit);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count   <= '0;
            run_bit <= 1'b0;
            edged   <= 1'b0;
            bitout  <= 1'b1;
            valid   <= 1'b0;
            stuff   <= 1'b0;
            stferr  <= 1'b0;
        end else begin
            valid <= 1'b0;
            edged <= activ;
            if (strobe) begin
                bitout <= bitin;
                if (direct) begin
                    valid <= 1'b1;
                    stuff <= 1'b0;
                    count <= '0;
                end else if (count == '0) begin
                    run_bit <= bitin;
                    count   <= 3'd1;
                    valid   <= 1'b1;
                    stuff   <= 1'b0;
                end else if (count == RUN_MAX) begin
                    if (bitin != run_bit) begin
                        // Stuff bit is discarded but starts the next run.
                        run_bit <= bitin;
                        count   <= 3'd1;
                        stuff   <= 1'b1;
                    end else begin
                        stferr <= 1'b1;
                        stuff  <= 1'b0;
                        count  <= '0;
                    end
                end else if (bitin == run_bit) begin
                    count <= count + 3'd1;
                    valid <= 1'b1;
                    stuff <= 1'b0;
                end else begin
                    run_bit <= bitin;
                    count   <= 3'd1;
                    valid   <= 1'b1;
                    stuff   <= 1'b0;
                end
            end
        end
    end

`ifdef DESTUFF_STFCNT_EN
    logic [2:0] stf_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stf_q <= '0;
        end else if (stuff_hit) begin
            stf_q <= stf_q + 3'd1;
        end
    end

    assign stfcnt = stf_q;
`else
    assign stfcnt = 3'b000;
`endif

endmodule
